// File: rtl/dbg_stream_loader.sv
// dbg_stream_loader: turns a framed byte stream into writes on the SoC debug
// memory port and holds the CPU in reset while a load is in progress.
// Frame: SYNC, ADDR (LE), COUNT (LE), COUNT words of data (LE) [, checksum].
// COUNT == 0 is the run command and releases cpu_n_reset.
// Optional: define DBG_STREAM_LOADER_CHECKSUM_EN to append and verify an
// 8-bit zero-sum checksum byte per frame (adds the CSUM/ERR states).
module dbg_stream_loader #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned WR_CYCLES = 4,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                cpu_n_reset,
    output logic                dbg_mem_op,
    output logic [DATA_W/8-1:0] dbg_wren,
    output logic [ADDR_W-1:0]   dbg_adr,
    output logic [DATA_W-1:0]   dbg_do,
    output logic                busy,
    output logic                err
);

    localparam int unsigned BYTES     = DATA_W / 8;
    localparam logic [7:0]  ADDR_LAST = 8'(ADDR_W / 8 - 1);
    localparam logic [7:0]  CNT_LAST  = 8'(CNT_W / 8 - 1);
    localparam logic [7:0]  DATA_LAST = 8'(BYTES - 1);
    localparam logic [15:0] WC_LAST   = 16'(WR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_DATA,
        S_WRITE,
        S_RUN
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
        , S_CSUM,
        S_ERR
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          byte_cnt_q, byte_cnt_d;
    logic [15:0]         wcyc_q, wcyc_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   do_q, do_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cpu_n_reset_q, cpu_n_reset_d;
    logic                busy_q, busy_d;
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          csum_nxt;
    logic                run_q, run_d;
    logic                err_q, err_d;
`endif

    logic                accept;
    logic [CNT_W-1:0]    cnt_shift;

    assign accept    = in_valid & in_ready;
    assign cnt_shift = CNT_W'({in_data, cnt_q} >> 8);

    // Port outputs decode straight from registers so an async reset clears them at once
    assign in_ready    = (state_q != S_WRITE) && (state_q != S_RUN);
    assign dbg_mem_op  = (state_q == S_WRITE);
    assign dbg_wren    = {BYTES{dbg_mem_op}};
    assign dbg_adr     = adr_q;
    assign dbg_do      = do_q;
    assign cpu_n_reset = cpu_n_reset_q;
    assign busy        = busy_q;
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
    assign err         = err_q;
    assign csum_nxt    = csum_q + in_data;
`else
    assign err         = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= '0;
            wcyc_q        <= '0;
            adr_q         <= '0;
            do_q          <= '0;
            cnt_q         <= '0;
            cpu_n_reset_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
            csum_q        <= '0;
            run_q         <= 1'b0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            wcyc_q        <= wcyc_d;
            adr_q         <= adr_d;
            do_q          <= do_d;
            cnt_q         <= cnt_d;
            cpu_n_reset_q <= cpu_n_reset_d;
            busy_q        <= busy_d;
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
            csum_q        <= csum_d;
            run_q         <= run_d;
            err_q         <= err_d;
`endif
        end
    end

    // Frame parser: next-state and datapath updates
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        wcyc_d        = wcyc_q;
        adr_d         = adr_q;
        do_d          = do_q;
        cnt_d         = cnt_q;
        cpu_n_reset_d = cpu_n_reset_q;
        busy_d        = busy_q;
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
        csum_d        = csum_q;
        run_d         = run_q;
        err_d         = err_q;
        if (accept && (state_q == S_ADDR || state_q == S_CNT || state_q == S_DATA))
            csum_d = csum_nxt;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept && in_data == SYNC) begin
                    state_d       = S_ADDR;
                    busy_d        = 1'b1;
                    cpu_n_reset_d = 1'b0;
                    byte_cnt_d    = '0;
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
                    csum_d        = '0;
                    err_d         = 1'b0;
`endif
                end
            end
            S_ADDR: begin
                if (accept) begin
                    adr_d = ADDR_W'({in_data, adr_q} >> 8);
                    if (byte_cnt_q == ADDR_LAST) begin
                        byte_cnt_d = '0;
                        state_d    = S_CNT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            S_CNT: begin
                if (accept) begin
                    cnt_d = cnt_shift;
                    if (byte_cnt_q == CNT_LAST) begin
                        byte_cnt_d = '0;
                        if (cnt_shift == '0) begin
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
                            run_d         = 1'b1;
                            state_d       = S_CSUM;
`else
                            state_d       = S_RUN;
                            cpu_n_reset_d = 1'b1;
                            busy_d        = 1'b0;
`endif
                        end else begin
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
                            run_d   = 1'b0;
`endif
                            state_d = S_DATA;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    do_d = DATA_W'({in_data, do_q} >> 8);
                    if (byte_cnt_q == DATA_LAST) begin
                        byte_cnt_d = '0;
                        wcyc_d     = '0;
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            S_WRITE: begin
                if (wcyc_q == WC_LAST) begin
                    adr_d = adr_q + ADDR_W'(BYTES);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    wcyc_d = wcyc_q + 16'd1;
                end
            end
            S_RUN: begin
                state_d = S_IDLE;
            end
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (csum_nxt == 8'd0) begin
                        if (run_q) begin
                            state_d       = S_RUN;
                            cpu_n_reset_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d       = S_ERR;
                        err_d         = 1'b1;
                        cpu_n_reset_d = 1'b0;
                    end
                end
            end
            S_ERR: begin
                if (accept && in_data == SYNC) begin
                    state_d       = S_ADDR;
                    busy_d        = 1'b1;
                    cpu_n_reset_d = 1'b0;
                    byte_cnt_d    = '0;
                    csum_d        = '0;
                    err_d         = 1'b0;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dbg_stream_loader.sv
// Directed testbench for dbg_stream_loader (default parameters).
module tb_dbg_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        cpu_n_reset;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;
    int last_wait = 0;
    logic [7:0] tb_sum = 8'h00;

    // Write log built by the port monitor
    logic [31:0] log_adr[$];
    logic [31:0] log_do[$];
    int          log_len[$];
    bit          log_ok[$];
    int          wr_len = 0;
    logic [31:0] cur_adr, cur_do;
    bit          cur_ok;

    dbg_stream_loader #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(16), .WR_CYCLES(4), .SYNC(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .cpu_n_reset(cpu_n_reset), .dbg_mem_op(dbg_mem_op),
        .dbg_wren(dbg_wren), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Record each write burst: start address/data, length, stability of port
    always @(negedge clk) begin
        if (dbg_mem_op === 1'b1) begin
            if (wr_len == 0) begin
                cur_adr = dbg_adr;
                cur_do  = dbg_do;
                cur_ok  = (dbg_wren === 4'hF) && (in_ready === 1'b0);
            end else if (dbg_adr !== cur_adr || dbg_do !== cur_do ||
                         dbg_wren !== 4'hF || in_ready !== 1'b0) begin
                cur_ok = 1'b0;
            end
            wr_len++;
        end else if (wr_len != 0) begin
            log_adr.push_back(cur_adr);
            log_do.push_back(cur_do);
            log_len.push_back(wr_len);
            log_ok.push_back(cur_ok);
            wr_len = 0;
        end
    end

    task automatic clear_log();
        log_adr.delete(); log_do.delete(); log_len.delete(); log_ok.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        last_wait = w;
        n_cmp++;
        if (w >= 50) begin
            $display("FAIL send_byte_ready: in_ready=%b required 1 within 50 cycles", in_ready);
            n_err++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tb_sum   = tb_sum + b;
    endtask

    task automatic send_sync();
        send_byte(8'hA5);
        tb_sum = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int unsigned i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)));
    endtask

    task automatic send_csum();
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
        send_byte(8'h00 - tb_sum);
`endif
    endtask

    task automatic wait_not_busy(input string name);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            $display("FAIL %s_busy_timeout: busy=%b required 0", name, busy);
            n_err++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (cpu_n_reset !== 1'b0) begin $display("FAIL reset_cpu_n_reset: got %b exp 0", cpu_n_reset); n_err++; end
        n_cmp++; if (dbg_mem_op !== 1'b0) begin $display("FAIL reset_mem_op: got %b exp 0", dbg_mem_op); n_err++; end
        n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b exp 1", in_ready); n_err++; end
        n_cmp++; if ({busy, err, dbg_wren} !== 6'b0) begin $display("FAIL reset_busy_err_wren: got %b exp 0", {busy, err, dbg_wren}); n_err++; end
        n_cmp++; if ({dbg_adr, dbg_do} !== 64'h0) begin $display("FAIL reset_adr_do: got %h exp 0", {dbg_adr, dbg_do}); n_err++; end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_preload();
        logic [31:0] ea[3];
        logic [31:0] ed[3];
        ea = '{32'h0002_0000, 32'h0002_0004, 32'h0002_0008};
        ed = '{32'h0000_006F, 32'h0000_0001, 32'h0000_0002};
        clear_log();
        send_sync();
        n_cmp++; if (busy !== 1'b1) begin $display("FAIL preload_busy_after_sync: got %b exp 1", busy); n_err++; end
        send_word(32'h0002_0000);
        n_cmp++; if (dbg_adr !== 32'h0002_0000) begin $display("FAIL preload_adr_field: got %h exp 00020000", dbg_adr); n_err++; end
        send_byte(8'h03); send_byte(8'h00);
        for (int i = 0; i < 3; i++) send_word(ed[i]);
        send_csum();
        wait_not_busy("preload");
        n_cmp++; if (log_adr.size() != 3) begin $display("FAIL preload_write_count: got %0d exp 3", log_adr.size()); n_err++; end
        for (int i = 0; i < 3; i++) begin
            if (i < log_adr.size()) begin
                n_cmp++; if (log_adr[i] !== ea[i]) begin $display("FAIL preload_adr%0d: got %h exp %h", i, log_adr[i], ea[i]); n_err++; end
                n_cmp++; if (log_do[i] !== ed[i]) begin $display("FAIL preload_do%0d: got %h exp %h", i, log_do[i], ed[i]); n_err++; end
                n_cmp++; if (log_len[i] != 4) begin $display("FAIL preload_len%0d: got %0d exp 4", i, log_len[i]); n_err++; end
                n_cmp++; if (!log_ok[i]) begin $display("FAIL preload_stable%0d: got unstable exp stable", i); n_err++; end
            end
        end
        n_cmp++; if (cpu_n_reset !== 1'b0) begin $display("FAIL preload_cpu_held: got %b exp 0", cpu_n_reset); n_err++; end
    endtask

    task automatic test_run();
        clear_log();
        send_sync();
        send_word(32'h0);
        send_byte(8'h00);
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        n_cmp++; if (cpu_n_reset !== 1'b0) begin $display("FAIL run_before_last: got %b exp 0", cpu_n_reset); n_err++; end
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
        send_csum();
`else
        send_byte(8'h00);
`endif
        n_cmp++; if (cpu_n_reset !== 1'b1) begin $display("FAIL run_cpu_release: got %b exp 1", cpu_n_reset); n_err++; end
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL run_busy: got %b exp 0", busy); n_err++; end
        repeat (3) @(negedge clk);
        n_cmp++; if (cpu_n_reset !== 1'b1) begin $display("FAIL run_cpu_stays: got %b exp 1", cpu_n_reset); n_err++; end
        n_cmp++; if (log_adr.size() != 0) begin $display("FAIL run_no_write: got %0d writes exp 0", log_adr.size()); n_err++; end
    endtask

    task automatic test_wrap();
        clear_log();
        send_byte(8'h11); send_byte(8'h22);
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL wrap_junk_busy: got %b exp 0", busy); n_err++; end
        send_sync();
        n_cmp++; if (cpu_n_reset !== 1'b0) begin $display("FAIL wrap_sync_holds_cpu: got %b exp 0", cpu_n_reset); n_err++; end
        send_word(32'hFFFF_FFFC);
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'hDEAD_BEEF);
        send_csum();
        wait_not_busy("wrap1");
        n_cmp++; if (log_adr.size() != 1) begin $display("FAIL wrap1_count: got %0d exp 1", log_adr.size()); n_err++; end
        else begin
            n_cmp++; if (log_adr[0] !== 32'hFFFF_FFFC) begin $display("FAIL wrap1_adr: got %h exp FFFFFFFC", log_adr[0]); n_err++; end
            n_cmp++; if (log_do[0] !== 32'hDEAD_BEEF) begin $display("FAIL wrap1_do: got %h exp DEADBEEF", log_do[0]); n_err++; end
        end
        n_cmp++; if (dbg_adr !== 32'h0) begin $display("FAIL wrap_next_adr: got %h exp 00000000", dbg_adr); n_err++; end
        clear_log();
        send_sync();
        send_word(32'hFFFF_FFFC);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_csum();
        wait_not_busy("wrap2");
        n_cmp++; if (log_adr.size() != 2) begin $display("FAIL wrap2_count: got %0d exp 2", log_adr.size()); n_err++; end
        else begin
            n_cmp++; if (log_adr[0] !== 32'hFFFF_FFFC) begin $display("FAIL wrap2_adr0: got %h exp FFFFFFFC", log_adr[0]); n_err++; end
            n_cmp++; if (log_adr[1] !== 32'h0000_0000) begin $display("FAIL wrap2_adr1: got %h exp 00000000", log_adr[1]); n_err++; end
            n_cmp++; if (log_do[1] !== 32'h2222_2222) begin $display("FAIL wrap2_do1: got %h exp 22222222", log_do[1]); n_err++; end
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_sync();
        send_word(32'h0000_0100);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'hA5); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h01);
        n_cmp++; if (last_wait != 4) begin $display("FAIL b2b_ready_low_cycles: got %0d exp 4", last_wait); n_err++; end
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_csum();
        wait_not_busy("b2b");
        n_cmp++; if (log_adr.size() != 2) begin $display("FAIL b2b_count: got %0d exp 2", log_adr.size()); n_err++; end
        else begin
            n_cmp++; if (log_do[0] !== 32'h1234_A578) begin $display("FAIL b2b_do0: got %h exp 1234A578", log_do[0]); n_err++; end
            n_cmp++; if (log_do[1] !== 32'h0403_0201) begin $display("FAIL b2b_do1: got %h exp 04030201", log_do[1]); n_err++; end
            n_cmp++; if (log_adr[1] !== 32'h0000_0104) begin $display("FAIL b2b_adr1: got %h exp 00000104", log_adr[1]); n_err++; end
            n_cmp++; if (log_len[1] != 4 || !log_ok[1]) begin $display("FAIL b2b_len1: got len %0d ok %0d exp len 4 ok 1", log_len[1], log_ok[1]); n_err++; end
        end
    endtask

    task automatic test_reset_mid_write();
        send_sync();
        send_word(32'h0000_0040);
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'hDDCC_BBAA);
        n_cmp++; if (dbg_mem_op !== 1'b1) begin $display("FAIL midrst_in_write: got %b exp 1", dbg_mem_op); n_err++; end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_cmp++; if ({dbg_mem_op, dbg_wren, busy, cpu_n_reset} !== 7'b0) begin
            $display("FAIL midrst_port: got op/wren/busy/cpu %b exp 0", {dbg_mem_op, dbg_wren, busy, cpu_n_reset}); n_err++; end
        n_cmp++; if ({dbg_adr, dbg_do} !== 64'h0 || in_ready !== 1'b1) begin
            $display("FAIL midrst_adr_do_ready: got %h ready %b exp 0 ready 1", {dbg_adr, dbg_do}, in_ready); n_err++; end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
        send_sync();
        send_word(32'h0000_0010);
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h1122_3344);
        send_csum();
        wait_not_busy("midrst");
        n_cmp++; if (log_adr.size() != 1) begin $display("FAIL midrst_new_count: got %0d exp 1", log_adr.size()); n_err++; end
        else begin
            n_cmp++; if (log_adr[0] !== 32'h10 || log_do[0] !== 32'h1122_3344 || log_len[0] != 4) begin
                $display("FAIL midrst_new_write: got %h/%h/%0d exp 00000010/11223344/4", log_adr[0], log_do[0], log_len[0]); n_err++; end
        end
    endtask

`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        send_sync();
        send_word(32'h0); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00);
        n_cmp++; if (cpu_n_reset !== 1'b1 || err !== 1'b0) begin $display("FAIL csum_good: got cpu %b err %b exp 1 0", cpu_n_reset, err); n_err++; end
        send_sync();
        send_word(32'h0); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01);
        n_cmp++; if (err !== 1'b1 || cpu_n_reset !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL csum_bad: got err %b cpu %b busy %b exp 1 0 0", err, cpu_n_reset, busy); n_err++; end
        send_byte(8'h33);
        n_cmp++; if (err !== 1'b1) begin $display("FAIL csum_err_sticky: got %b exp 1", err); n_err++; end
        send_sync();
        n_cmp++; if (err !== 1'b0 || busy !== 1'b1) begin $display("FAIL csum_sync_clears: got err %b busy %b exp 0 1", err, busy); n_err++; end
        send_word(32'h0); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00);
        n_cmp++; if (cpu_n_reset !== 1'b1) begin $display("FAIL csum_recover_run: got %b exp 1", cpu_n_reset); n_err++; end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_preload();
        test_run();
        test_wrap();
        test_back_to_back();
        test_reset_mid_write();
`ifdef DBG_STREAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
